spec_vram_arbiter: RTL
======================

SPEC_VRAM_ARBITER -- requirements
Module: spec_vram_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 6: CPU wait-cycle limit before the CPU overrides video priority; range 1..15.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 clock_16  input  1  16 MHz clock; all logic on its rising edge.
REQ-004 vid_req  input  1  one-cycle pulse requesting one 16-bit video word.
REQ-005 vid_addr  input  14  video word address, sampled with vid_req.
REQ-006 vid_data  output  16  fetched video word, valid while vid_valid=1.
REQ-007 vid_valid  output  1  one-cycle pulse: vid_data updated.
REQ-008 vid_overrun  output  1  sticky flag: video request lost.
REQ-009 cpu_req  input  1  level; held high until cpu_ack.
REQ-010 cpu_we  input  1  1=write, 0=read; sampled at grant.
REQ-011 cpu_addr  input  14  CPU word address, sampled at grant.
REQ-012 cpu_wdata  input  8  pixel byte for write.
REQ-013 cpu_color  input  3  colour attribute written with pixel byte.
REQ-014 cpu_rdata  output  8  read data (ram_rdata[7:0]), valid while cpu_ack=1.
REQ-015 cpu_ack  output  1  one-cycle pulse: CPU access complete.
REQ-016 ram_addr  output  14  SRAM word address.
REQ-017 ram_wdata  output  16  SRAM write data = {5'b0, cpu_color, cpu_wdata}.
REQ-018 ram_rdata  input  16  SRAM read data.
REQ-019 ram_oe_n / ram_we_n  output  1 each  SRAM strobes, active-low.

Function
REQ-020 States: IDLE, ACC1, ACC2, TURN; state, strobes, addresses and data outputs are registered.
REQ-021 Video request latched into vid_pending/vid_addr_q on vid_req in any state; pending cleared at video grant.
REQ-022 vid_req while vid_pending=1 and not granted that cycle: new address replaces old, vid_overrun set; cleared only by reset.
REQ-023 CPU request is new when cpu_req=1 and cpu_done=0; cpu_done set with cpu_ack, cleared when cpu_req=0.
REQ-024 cpu_wait: 4-bit counter, increments each cycle a new CPU request is not granted, saturates at 15, clears at CPU grant.
REQ-025 Grant decision in IDLE and ACC2: CPU if CPU new and (no video pending or cpu_wait>=MAX_WAIT); else video if pending; else IDLE.
REQ-026 Grant moves to ACC1 next cycle: ram_addr loaded; read drives ram_oe_n=0; write drives ram_we_n=0 and ram_wdata.
REQ-027 ACC2 holds address, data and strobes; ram_rdata sampled at end of ACC2.
REQ-028 Cycle after ACC2: strobes high unless a read is granted back-to-back (ram_oe_n stays 0, new address).
REQ-029 Completion pulses in cycle after ACC2: vid_valid with vid_data, or cpu_ack with cpu_rdata; write ack carries unchanged cpu_rdata.
REQ-030 After a write, ACC2 goes to TURN (strobes high, one cycle), then IDLE; no grant is decided in TURN.
REQ-031 Latency: request sampled idle at edge n -> ACC1 n+1, ACC2 n+2, completion pulse n+3; read throughput one word per 2 cycles.
REQ-032 ram_oe_n and ram_we_n are never both 0.
REQ-033 Simultaneous vid_req and video grant: the granted (old) address is used; the new request stays pending; no overrun.

Reset
REQ-034 reset_n=0 forces immediately: state IDLE, ram_oe_n=1, ram_we_n=1, ram_addr=0, ram_wdata=0, vid_data=0, vid_valid=0, cpu_rdata=0, cpu_ack=0, vid_overrun=0, vid_pending=0, cpu_done=0, cpu_wait=0.
REQ-035 Reset during ACC1/ACC2 aborts the access without completion pulse; the first grant is decided in the first cycle after release.

Verification
REQ-036 Idle, vid_req with vid_addr=0x0123, ram_rdata=0xA55A -> oe_n low 2 cycles at 0x0123; vid_valid 3 cycles after req, vid_data=0xA55A.
REQ-037 CPU write addr 0x1000, wdata 0x3C, color 5 -> we_n low 2 cycles, ram_wdata=0x053C, cpu_ack, then TURN with strobes high.
REQ-038 vid_req every 2 cycles plus constant CPU read request, MAX_WAIT=6 -> CPU granted by cpu_wait=6, cpu_ack within 10 cycles of cpu_req.
REQ-039 Two vid_req 1 cycle apart while CPU write in progress -> vid_overrun=1; one vid_valid with second address data.
REQ-040 reset_n low during ACC2 of CPU read -> strobes high at once, no cpu_ack; after release, held cpu_req is served normally.

Source files
------------

// File: rtl/spec_vram_arbiter.sv
// Video/CPU arbiter for a single asynchronous 16-bit SRAM.
// Video has priority until a starving CPU request has waited MAX_WAIT cycles.
`timescale 1ns/1ps
module spec_vram_arbiter #(
    parameter int MAX_WAIT = 6
) (
    input  logic        reset_n,
    input  logic        clock_16,
    input  logic        vid_req,
    input  logic [13:0] vid_addr,
    output logic [15:0] vid_data,
    output logic        vid_valid,
    output logic        vid_overrun,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic [2:0]  cpu_color,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [13:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, TURN} state_t;

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    state_t      state, state_d;
    logic        vid_pending, vid_pending_d;
    logic [13:0] vid_addr_q, vid_addr_q_d;
    logic        vid_overrun_d;
    logic        cpu_done, cpu_done_d;
    logic [3:0]  cpu_wait, cpu_wait_d;
    logic        cur_cpu, cur_cpu_d;
    logic        cur_we, cur_we_d;
    logic [15:0] vid_data_d;
    logic        vid_valid_d;
    logic [7:0]  cpu_rdata_d;
    logic        cpu_ack_d;
    logic [13:0] ram_addr_d;
    logic [15:0] ram_wdata_d;
    logic        ram_oe_n_d, ram_we_n_d;

    logic cpu_busy, cpu_new, decide, grant_cpu, grant_vid;

    // A CPU access already in flight must not count as a fresh request,
    // since cpu_done only rises together with its ack.
    assign cpu_busy  = cur_cpu && ((state == ACC1) || (state == ACC2));
    assign cpu_new   = cpu_req && !cpu_done && !cpu_busy;
    assign decide    = (state == IDLE) || ((state == ACC2) && !cur_we);
    assign grant_cpu = decide && cpu_new && (!vid_pending || (cpu_wait >= WAIT_LIM));
    assign grant_vid = decide && !grant_cpu && vid_pending;

    always_comb begin
        state_d       = state;
        vid_pending_d = vid_pending;
        vid_addr_q_d  = vid_addr_q;
        vid_overrun_d = vid_overrun;
        cpu_done_d    = cpu_done;
        cpu_wait_d    = cpu_wait;
        cur_cpu_d     = cur_cpu;
        cur_we_d      = cur_we;
        vid_data_d    = vid_data;
        vid_valid_d   = 1'b0;
        cpu_rdata_d   = cpu_rdata;
        cpu_ack_d     = 1'b0;
        ram_addr_d    = ram_addr;
        ram_wdata_d   = ram_wdata;
        ram_oe_n_d    = ram_oe_n;
        ram_we_n_d    = ram_we_n;

        // A grant consumes the old address; a same-cycle request re-arms pending.
        if (grant_vid)
            vid_pending_d = 1'b0;
        if (vid_req) begin
            if (vid_pending && !grant_vid)
                vid_overrun_d = 1'b1;
            vid_pending_d = 1'b1;
            vid_addr_q_d  = vid_addr;
        end

        if (grant_cpu)
            cpu_wait_d = 4'd0;
        else if (cpu_new && (cpu_wait != 4'hF))
            cpu_wait_d = cpu_wait + 4'd1;

        if (!cpu_req)
            cpu_done_d = 1'b0;

        case (state)
            ACC1: state_d = ACC2;
            ACC2: begin
                ram_oe_n_d = 1'b1;
                ram_we_n_d = 1'b1;
                state_d    = cur_we ? TURN : IDLE;
                if (cur_cpu) begin
                    cpu_ack_d  = 1'b1;
                    cpu_done_d = 1'b1;
                    if (!cur_we)
                        cpu_rdata_d = ram_rdata[7:0];
                end else begin
                    vid_valid_d = 1'b1;
                    vid_data_d  = ram_rdata;
                end
            end
            TURN: begin
                ram_oe_n_d = 1'b1;
                ram_we_n_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
            end
        endcase

        // Back-to-back read from ACC2 keeps oe_n low with the new address.
        if (grant_cpu) begin
            state_d    = ACC1;
            cur_cpu_d  = 1'b1;
            cur_we_d   = cpu_we;
            ram_addr_d = cpu_addr;
            ram_oe_n_d = cpu_we;
            ram_we_n_d = !cpu_we;
            if (cpu_we)
                ram_wdata_d = {5'b0, cpu_color, cpu_wdata};
        end else if (grant_vid) begin
            state_d    = ACC1;
            cur_cpu_d  = 1'b0;
            cur_we_d   = 1'b0;
            ram_addr_d = vid_addr_q;
            ram_oe_n_d = 1'b0;
            ram_we_n_d = 1'b1;
        end
    end

    always_ff @(posedge clock_16 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            vid_pending <= 1'b0;
            vid_addr_q  <= 14'd0;
            vid_overrun <= 1'b0;
            cpu_done    <= 1'b0;
            cpu_wait    <= 4'd0;
            cur_cpu     <= 1'b0;
            cur_we      <= 1'b0;
            vid_data    <= 16'd0;
            vid_valid   <= 1'b0;
            cpu_rdata   <= 8'd0;
            cpu_ack     <= 1'b0;
            ram_addr    <= 14'd0;
            ram_wdata   <= 16'd0;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
        end else begin
            state       <= state_d;
            vid_pending <= vid_pending_d;
            vid_addr_q  <= vid_addr_q_d;
            vid_overrun <= vid_overrun_d;
            cpu_done    <= cpu_done_d;
            cpu_wait    <= cpu_wait_d;
            cur_cpu     <= cur_cpu_d;
            cur_we      <= cur_we_d;
            vid_data    <= vid_data_d;
            vid_valid   <= vid_valid_d;
            cpu_rdata   <= cpu_rdata_d;
            cpu_ack     <= cpu_ack_d;
            ram_addr    <= ram_addr_d;
            ram_wdata   <= ram_wdata_d;
            ram_oe_n    <= ram_oe_n_d;
            ram_we_n    <= ram_we_n_d;
        end
    end

endmodule
